// File: rtl/network_interface_pos_tx_pkg.sv
// Shared types and constants for the position-traffic k2n transmitter.
// A beat is LANES_PER_BEAT position records side by side, lane 0 in the low bits.
package network_interface_pos_tx_pkg;

  localparam int AXIS_TDATA_WIDTH      = 512;
  localparam int STREAMING_TDEST_WIDTH = 16;
  localparam int RECORD_WIDTH          = 128;
  localparam int LANES_PER_BEAT        = AXIS_TDATA_WIDTH / RECORD_WIDTH;
  localparam int LANE_BYTES            = RECORD_WIDTH / 8;
  localparam int KEEP_WIDTH            = AXIS_TDATA_WIDTH / 8;
  localparam int LANE_CNT_W            = (LANES_PER_BEAT > 1) ? $clog2(LANES_PER_BEAT) : 1;

  typedef logic [RECORD_WIDTH-1:0] pos_record_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } tx_state_t;

  typedef struct packed {
    logic [AXIS_TDATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0]       keep;
  } beat_t;

  // Each written lane owns LANE_BYTES consecutive tkeep bits.
  function automatic logic [KEEP_WIDTH-1:0] lanes_to_keep(input logic [LANES_PER_BEAT-1:0] mask);
    logic [KEEP_WIDTH-1:0] k;
    k = '0;
    for (int i = 0; i < LANES_PER_BEAT; i++) begin
      k[i*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{mask[i]}};
    end
    return k;
  endfunction

endpackage

// File: rtl/network_interface_pos_tx_packer.sv
// Lane buffer for one beat: collects records into lanes, tracks which lanes were written,
// and holds a closed beat when the output register downstream is still occupied.
module network_interface_pos_tx_packer
  import network_interface_pos_tx_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        wr_en,
  input  pos_record_t wr_data,
  input  logic        wr_last,
  input  logic        out_free,
  output logic        full,
  output logic        beat_avail,
  output beat_t       beat
);

  localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(LANES_PER_BEAT - 1);

  logic [LANES_PER_BEAT-1:0][RECORD_WIDTH-1:0] lane_q, lane_d, merged;
  logic [LANES_PER_BEAT-1:0]                   mask_q, mask_d, merged_mask;
  logic [LANE_CNT_W-1:0]                       lane_cnt_q, lane_cnt_d;
  logic                                        full_q, full_d;
  logic                                        close;

  // Buffer contents as they would look with this cycle's record folded in; this is
  // what lets a closing record reach the output register on the very next edge.
  always_comb begin
    merged      = lane_q;
    merged_mask = mask_q;
    for (int i = 0; i < LANES_PER_BEAT; i++) begin
      if (wr_en && (lane_cnt_q == LANE_CNT_W'(i))) begin
        merged[i]      = wr_data;
        merged_mask[i] = 1'b1;
      end
    end
  end

  assign close      = wr_en && ((lane_cnt_q == LAST_LANE) || wr_last);
  assign beat_avail = full_q || close;
  assign full       = full_q;
  assign beat.data  = merged;
  assign beat.keep  = lanes_to_keep(merged_mask);

  always_comb begin
    lane_d     = lane_q;
    mask_d     = mask_q;
    lane_cnt_d = lane_cnt_q;
    full_d     = full_q;
    if (full_q) begin
      if (out_free) begin
        lane_d     = '0;
        mask_d     = '0;
        lane_cnt_d = '0;
        full_d     = 1'b0;
      end
    end else if (close) begin
      lane_cnt_d = '0;
      if (out_free) begin
        lane_d = '0;
        mask_d = '0;
      end else begin
        lane_d = merged;
        mask_d = merged_mask;
        full_d = 1'b1;
      end
    end else if (wr_en) begin
      lane_d     = merged;
      mask_d     = merged_mask;
      lane_cnt_d = lane_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      lane_q     <= '0;
      mask_q     <= '0;
      lane_cnt_q <= '0;
      full_q     <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      mask_q     <= mask_d;
      lane_cnt_q <= lane_cnt_d;
      full_q     <= full_d;
    end
  end

endmodule

// File: rtl/network_interface_pos_tx.sv
// Position-record transmitter: packs 128-bit records into 512-bit k2n beats, one packet
// per beat, for a run of number_packets beats started by ap_start.
module network_interface_pos_tx
  import network_interface_pos_tx_pkg::*;
(
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic                             reset_fsm_n,
  input  logic                             ap_start,
  input  logic [31:0]                      number_packets,
  input  logic [STREAMING_TDEST_WIDTH-1:0] dest_id,
  output logic                             ap_idle,
  output logic                             ap_done,
  input  logic [RECORD_WIDTH-1:0]          rec_data,
  input  logic                             rec_valid,
  input  logic                             rec_last,
  output logic                             rec_ready,
  output logic [AXIS_TDATA_WIDTH-1:0]      M_AXIS_k2n_tdata,
  output logic [KEEP_WIDTH-1:0]            M_AXIS_k2n_tkeep,
  output logic                             M_AXIS_k2n_tvalid,
  output logic                             M_AXIS_k2n_tlast,
  output logic [STREAMING_TDEST_WIDTH-1:0] M_AXIS_k2n_tdest,
  input  logic                             M_AXIS_k2n_tready
);

  tx_state_t                        state_q, state_d;
  logic [31:0]                      np_q, np_d;
  logic [31:0]                      beat_cnt_q, beat_cnt_d;
  logic [STREAMING_TDEST_WIDTH-1:0] dest_q, dest_d;
  logic [AXIS_TDATA_WIDTH-1:0]      tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0]            tkeep_q, tkeep_d;
  logic                             tvalid_q, tvalid_d;
  logic                             tlast_q, tlast_d;
  logic                             ap_done_q, ap_done_d;
  logic                             ap_idle_q, ap_idle_d;

  logic  rst, hs, out_free, load, wr_en, pk_clear, pk_full, pk_avail;
  beat_t pk_beat;

  assign rst      = ap_rst | ~reset_fsm_n;
  assign hs       = tvalid_q & M_AXIS_k2n_tready;
  assign out_free = ~tvalid_q | M_AXIS_k2n_tready;
  assign load     = (state_q == FILL) & pk_avail & out_free;
  // A held closed beat means the buffer cannot take another record until it moves out.
  assign rec_ready = (state_q == FILL) & ~pk_full;
  assign wr_en     = rec_valid & rec_ready;
  assign pk_clear  = rst | (state_q != FILL);

  network_interface_pos_tx_packer u_packer (
    .clk        (ap_clk),
    .clear      (pk_clear),
    .wr_en      (wr_en),
    .wr_data    (rec_data),
    .wr_last    (rec_last),
    .out_free   (out_free),
    .full       (pk_full),
    .beat_avail (pk_avail),
    .beat       (pk_beat)
  );

  always_comb begin
    state_d    = state_q;
    np_d       = np_q;
    dest_d     = dest_q;
    beat_cnt_d = beat_cnt_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    ap_done_d  = 1'b0;
    ap_idle_d  = ap_idle_q;
    unique case (state_q)
      IDLE: begin
        if (ap_start) begin
          np_d       = number_packets;
          dest_d     = dest_id;
          beat_cnt_d = '0;
          ap_idle_d  = 1'b0;
          if (number_packets == '0) begin
            state_d   = DONE;
            ap_done_d = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (load) begin
          tdata_d  = pk_beat.data;
          tkeep_d  = pk_beat.keep;
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
        end else if (hs) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
        if (hs) begin
          beat_cnt_d = beat_cnt_q + 32'd1;
          if (beat_cnt_d == np_q) begin
            state_d   = DONE;
            ap_done_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        ap_idle_d = 1'b1;
        tvalid_d  = 1'b0;
        tlast_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      np_q       <= '0;
      beat_cnt_q <= '0;
      dest_q     <= '0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_idle_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      np_q       <= np_d;
      beat_cnt_q <= beat_cnt_d;
      dest_q     <= dest_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      ap_done_q  <= ap_done_d;
      ap_idle_q  <= ap_idle_d;
    end
  end

  assign ap_idle           = ap_idle_q;
  assign ap_done           = ap_done_q;
  assign M_AXIS_k2n_tdata  = tdata_q;
  assign M_AXIS_k2n_tkeep  = tkeep_q;
  assign M_AXIS_k2n_tvalid = tvalid_q;
  assign M_AXIS_k2n_tlast  = tlast_q;
  assign M_AXIS_k2n_tdest  = dest_q;

endmodule

// File: tb/tb_network_interface_pos_tx.sv
// Bench for network_interface_pos_tx: randomized record streams and backpressure, checked
// against a record-grouping model of the expected beats.
module tb_network_interface_pos_tx;

  logic         ap_clk = 1'b0;
  logic         ap_rst, reset_fsm_n, ap_start;
  logic [31:0]  number_packets;
  logic [15:0]  dest_id;
  logic         ap_idle, ap_done;
  logic [127:0] rec_data;
  logic         rec_valid, rec_last, rec_ready;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tvalid, tlast, tready;
  logic [15:0]  tdest;

  network_interface_pos_tx dut (
    .ap_clk            (ap_clk),
    .ap_rst            (ap_rst),
    .reset_fsm_n       (reset_fsm_n),
    .ap_start          (ap_start),
    .number_packets    (number_packets),
    .dest_id           (dest_id),
    .ap_idle           (ap_idle),
    .ap_done           (ap_done),
    .rec_data          (rec_data),
    .rec_valid         (rec_valid),
    .rec_last          (rec_last),
    .rec_ready         (rec_ready),
    .M_AXIS_k2n_tdata  (tdata),
    .M_AXIS_k2n_tkeep  (tkeep),
    .M_AXIS_k2n_tvalid (tvalid),
    .M_AXIS_k2n_tlast  (tlast),
    .M_AXIS_k2n_tdest  (tdest),
    .M_AXIS_k2n_tready (tready)
  );

  always #5 ap_clk = ~ap_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] in_data[$];
  bit           in_last[$];
  logic [511:0] exp_data[$];
  logic [63:0]  exp_keep[$];
  logic [511:0] obs_data[$];
  logic [63:0]  obs_keep[$];
  logic [15:0]  obs_dest[$];
  bit           obs_last[$];
  int done_cnt, done_cyc, last_hs_cyc, first_v_cyc, stab_err, rd_low;

  // Expected beats straight from the rules: up to four records per beat, closed early by
  // rec_last, lane i at bits [128*i +: 128], 16 keep bits per used lane.
  task automatic build_model(input int np);
    logic [511:0] cur;
    int lanes;
    exp_data.delete(); exp_keep.delete();
    cur = '0; lanes = 0;
    foreach (in_data[i]) begin
      if (exp_data.size() < np) begin
        cur[128*lanes +: 128] = in_data[i];
        lanes++;
        if (lanes == 4 || in_last[i]) begin
          exp_data.push_back(cur);
          exp_keep.push_back(lanes == 4 ? {64{1'b1}} : ((64'd1 << (16*lanes)) - 64'd1));
          cur = '0; lanes = 0;
        end
      end
    end
  endtask

  task automatic gen_records(input int np);
    in_data.delete(); in_last.delete();
    for (int b = 0; b < np; b++) begin
      int nl;
      nl = $urandom_range(4, 1);
      for (int l = 0; l < nl; l++) begin
        in_data.push_back({$urandom, $urandom, $urandom, $urandom});
        in_last.push_back((l == nl-1) && (nl < 4 || $urandom_range(1) == 1));
      end
    end
  endtask

  // Drives one run from the negedge: start pulse on cycle 0, records, tready pattern;
  // records every handshaken beat and AXIS hold violations.
  task automatic run_sim(input int np, input logic [15:0] dest, input int stall_lo, input int stall_hi,
                         input bit rand_ready, input bit gaps, input int restart_cyc);
    int idx;
    logic pv, pr;
    logic [511:0] pd;
    logic [63:0] pk;
    logic [15:0] pdst;
    obs_data.delete(); obs_keep.delete(); obs_dest.delete(); obs_last.delete();
    done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; first_v_cyc = -1; stab_err = 0; rd_low = 0;
    idx = 0; pv = 0; pr = 0; pd = '0; pk = '0; pdst = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge ap_clk);
      if (ap_done) begin done_cnt++; done_cyc = c; end
      if (pv && !pr && (!tvalid || tdata !== pd || tkeep !== pk || tdest !== pdst)) stab_err++;
      if (tvalid && first_v_cyc < 0) first_v_cyc = c;
      ap_start       = (c == 0) || (c == restart_cyc);
      number_packets = (c == restart_cyc) ? 32'd99 : np;
      dest_id        = dest;
      if (c >= stall_lo && c < stall_hi) tready = 1'b0;
      else if (rand_ready)               tready = ($urandom_range(2) != 0);
      else                               tready = 1'b1;
      if (idx < in_data.size()) begin
        rec_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
        rec_data  = in_data[idx];
        rec_last  = in_last[idx];
        if (c >= 2 && !rec_ready) rd_low++;
        if (rec_valid && rec_ready) idx++;
      end else begin
        rec_valid = 1'b0; rec_data = '0; rec_last = 1'b0;
      end
      if (tvalid && tready) begin
        obs_data.push_back(tdata); obs_keep.push_back(tkeep);
        obs_dest.push_back(tdest); obs_last.push_back(tlast);
        last_hs_cyc = c;
      end
      pv = tvalid; pr = tready; pd = tdata; pk = tkeep; pdst = tdest;
      if (done_cnt > 0 && c >= done_cyc + 2) break;
    end
    ap_start = 1'b0; rec_valid = 1'b0; tready = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; reset_fsm_n = 1'b1; ap_start = 1'b0; number_packets = '0; dest_id = '0;
    rec_data = '0; rec_valid = 1'b0; rec_last = 1'b0; tready = 1'b0;
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    n_tests++;
    if ({ap_idle, ap_done, tvalid, tlast, rec_ready} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl got idle/done/tvalid/tlast/rdy=%b want 10000",
                         {ap_idle, ap_done, tvalid, tlast, rec_ready});
    end
    n_tests++;
    if (tdata !== '0 || tkeep !== '0 || tdest !== '0) begin
      n_fail++; $display("FAIL reset_data got tdata=%h tkeep=%h tdest=%h want 0", tdata, tkeep, tdest);
    end
  endtask

  task automatic test_basic();
    in_data.delete(); in_last.delete();
    for (int i = 1; i <= 8; i++) begin in_data.push_back(128'(i)); in_last.push_back(1'b0); end
    build_model(2);
    run_sim(2, 16'd10, -1, -1, 1'b0, 1'b0, -1);
    n_tests++;
    if (obs_data.size() !== 2) begin n_fail++; $display("FAIL basic_count got %0d want 2", obs_data.size()); end
    for (int k = 0; k < obs_data.size() && k < exp_data.size(); k++) begin
      n_tests++;
      if (obs_data[k] !== exp_data[k] || obs_keep[k] !== {64{1'b1}} || obs_dest[k] !== 16'd10 || obs_last[k] !== 1'b1) begin
        n_fail++; $display("FAIL basic_beat%0d got data=%h keep=%h dest=%0d last=%0d want data=%h keep=all-ones dest=10 last=1",
                           k, obs_data[k], obs_keep[k], obs_dest[k], obs_last[k], exp_data[k]);
      end
    end
    n_tests++;
    if (obs_data.size() > 0 && obs_data[0][127:0] !== 128'h1) begin
      n_fail++; $display("FAIL basic_lane0 got %h want 1", obs_data[0][127:0]);
    end
    n_tests++;
    if (first_v_cyc !== 5) begin n_fail++; $display("FAIL basic_latency got tvalid at cycle %0d want 5", first_v_cyc); end
    n_tests++;
    if (done_cnt !== 1 || done_cyc !== last_hs_cyc + 1) begin
      n_fail++; $display("FAIL basic_done got count=%0d at %0d want 1 at %0d", done_cnt, done_cyc, last_hs_cyc + 1);
    end
    n_tests++;
    if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL basic_idle got %b want 1", ap_idle); end
  endtask

  task automatic test_partial();
    in_data.delete(); in_last.delete();
    in_data.push_back(128'hA); in_last.push_back(1'b0);
    in_data.push_back(128'hB); in_last.push_back(1'b0);
    in_data.push_back(128'hC); in_last.push_back(1'b1);
    run_sim(1, 16'd3, -1, -1, 1'b0, 1'b1, -1);
    n_tests++;
    if (obs_data.size() !== 1) begin
      n_fail++; $display("FAIL partial_count got %0d want 1", obs_data.size());
    end else begin
      n_tests++;
      if (obs_keep[0] !== 64'h0000_FFFF_FFFF_FFFF || obs_data[0][511:384] !== '0 || obs_data[0][383:256] !== 128'hC) begin
        n_fail++; $display("FAIL partial_beat got keep=%h data=%h want keep=0000ffffffffffff lane2=c lane3=0",
                           obs_keep[0], obs_data[0]);
      end
    end
    // rec_last on the first record of a beat gives a single-lane packet.
    in_data.delete(); in_last.delete();
    in_data.push_back({$urandom, $urandom, $urandom, $urandom}); in_last.push_back(1'b1);
    run_sim(1, 16'd4, -1, -1, 1'b0, 1'b0, -1);
    n_tests++;
    if (obs_keep.size() !== 1 || obs_keep[0] !== 64'h0000_0000_0000_FFFF || obs_data[0][127:0] !== in_data[0]) begin
      n_fail++; $display("FAIL partial_lane0 got beats=%0d keep=%h want 1 beat keep=000000000000ffff",
                         obs_keep.size(), obs_keep.size() > 0 ? obs_keep[0] : 64'h0);
    end
  endtask

  task automatic test_stall();
    in_data.delete(); in_last.delete();
    for (int i = 0; i < 12; i++) begin in_data.push_back({$urandom, $urandom, $urandom, $urandom}); in_last.push_back(1'b0); end
    build_model(3);
    run_sim(3, 16'hBEEF, 5, 11, 1'b0, 1'b0, -1);
    n_tests++;
    if (stab_err !== 0) begin n_fail++; $display("FAIL stall_hold got %0d unstable cycles want 0", stab_err); end
    n_tests++;
    if (rd_low == 0) begin n_fail++; $display("FAIL stall_ready got %0d ready-low cycles want >0", rd_low); end
    n_tests++;
    if (obs_data.size() !== exp_data.size()) begin
      n_fail++; $display("FAIL stall_count got %0d want %0d", obs_data.size(), exp_data.size());
    end
    for (int k = 0; k < obs_data.size() && k < exp_data.size(); k++) begin
      n_tests++;
      if (obs_data[k] !== exp_data[k] || obs_keep[k] !== exp_keep[k] || obs_dest[k] !== 16'hBEEF) begin
        n_fail++; $display("FAIL stall_beat%0d got keep=%h dest=%h want keep=%h dest=beef", k, obs_keep[k], obs_dest[k], exp_keep[k]);
      end
    end
  endtask

  task automatic test_zero();
    in_data.delete(); in_last.delete();
    run_sim(0, 16'd5, -1, -1, 1'b0, 1'b0, -1);
    n_tests++;
    if (done_cnt !== 1 || done_cyc !== 1 || first_v_cyc !== -1 || obs_data.size() !== 0) begin
      n_fail++; $display("FAIL zero_run got done=%0d at %0d tvalid_at=%0d beats=%0d want done=1 at 1 no tvalid",
                         done_cnt, done_cyc, first_v_cyc, obs_data.size());
    end
    n_tests++;
    if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL zero_idle got %b want 1", ap_idle); end
  endtask

  task automatic test_soft_reset();
    @(negedge ap_clk);
    ap_start = 1'b1; number_packets = 32'd2; dest_id = 16'd7;
    @(negedge ap_clk);
    ap_start = 1'b0; tready = 1'b1;
    rec_valid = 1'b1; rec_last = 1'b0; rec_data = {4{32'h1111_1111}};
    @(negedge ap_clk);
    rec_data = {4{32'h2222_2222}};
    @(negedge ap_clk);
    rec_valid = 1'b0; reset_fsm_n = 1'b0;
    @(negedge ap_clk);
    reset_fsm_n = 1'b1;
    n_tests++;
    if ({ap_idle, ap_done, tvalid, tlast, rec_ready} !== 5'b10000 || tdata !== '0 || tkeep !== '0 || tdest !== '0) begin
      n_fail++; $display("FAIL softrst_outputs got idle/done/tvalid/tlast/rdy=%b tkeep=%h tdest=%h want 10000 and zeros",
                         {ap_idle, ap_done, tvalid, tlast, rec_ready}, tkeep, tdest);
    end
    gen_records(1);
    build_model(1);
    run_sim(1, 16'd8, -1, -1, 1'b0, 1'b0, -1);
    n_tests++;
    if (obs_data.size() !== 1 || obs_data[0] !== exp_data[0] || obs_keep[0] !== exp_keep[0]) begin
      n_fail++; $display("FAIL softrst_rerun got beats=%0d keep=%h want 1 beat keep=%h lane0=%h",
                         obs_data.size(), obs_keep.size() > 0 ? obs_keep[0] : 64'h0, exp_keep[0], in_data[0]);
    end
  endtask

  task automatic test_restart_ignored();
    gen_records(2);
    build_model(2);
    run_sim(2, 16'd12, -1, -1, 1'b1, 1'b1, 3);
    n_tests++;
    if (obs_data.size() !== 2 || done_cnt !== 1 || ap_idle !== 1'b1) begin
      n_fail++; $display("FAIL restart_ignored got beats=%0d done=%0d idle=%b want 2 beats done=1 idle=1",
                         obs_data.size(), done_cnt, ap_idle);
    end
    for (int k = 0; k < obs_data.size() && k < exp_data.size(); k++) begin
      n_tests++;
      if (obs_data[k] !== exp_data[k] || obs_keep[k] !== exp_keep[k]) begin
        n_fail++; $display("FAIL restart_beat%0d got keep=%h want %h", k, obs_keep[k], exp_keep[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int np;
      logic [15:0] d;
      np = $urandom_range(5, 1);
      d  = 16'($urandom);
      gen_records(np);
      build_model(np);
      run_sim(np, d, -1, -1, 1'b1, 1'b1, -1);
      n_tests++;
      if (obs_data.size() !== np || done_cnt !== 1 || done_cyc !== last_hs_cyc + 1 || stab_err !== 0) begin
        n_fail++; $display("FAIL rand%0d_run got beats=%0d done=%0d at %0d hold_err=%0d want beats=%0d done=1 at %0d",
                           r, obs_data.size(), done_cnt, done_cyc, stab_err, np, last_hs_cyc + 1);
      end
      for (int k = 0; k < obs_data.size() && k < exp_data.size(); k++) begin
        n_tests++;
        if (obs_data[k] !== exp_data[k] || obs_keep[k] !== exp_keep[k] || obs_dest[k] !== d || obs_last[k] !== 1'b1) begin
          n_fail++; $display("FAIL rand%0d_beat%0d got keep=%h dest=%h last=%0d want keep=%h dest=%h last=1",
                             r, k, obs_keep[k], obs_dest[k], obs_last[k], exp_keep[k], d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_stall();
    test_zero();
    test_soft_reset();
    test_restart_ignored();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
